// File: rtl/kfsdram_pkg.sv
// Shared KFSDRAM definitions: default user-port widths and the arbiter FSM state encoding.
package kfsdram_pkg;

    localparam int KFS_ADDR_W = 25;
    localparam int KFS_ACC_W  = 10;
    localparam int KFS_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_BUSY,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/kfsdram_rr_arbiter.sv
// Two-way round-robin pick. The pointer names the port that wins a tie and,
// after each grant, moves to the port that did not win.
module kfsdram_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       valid_o,
    output logic       winner_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        valid_o  = |req_i;
        winner_o = (req_i[0] && req_i[1]) ? ptr_q : req_i[1];
    end

    assign ptr_d = (advance_i && valid_o) ? ~winner_o : ptr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/kfsdram_arbiter.sv
// Two-port front end for the KFSDRAM controller: round-robin grant, one command
// pulse per burst, and status flags routed back only to the port that owns the burst.
module kfsdram_arbiter
    import kfsdram_pkg::*;
#(
    parameter int address_width = KFS_ADDR_W,
    parameter int access_width  = KFS_ACC_W,
    parameter int data_width    = KFS_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     p0_request,
    input  logic                     p0_write,
    input  logic [address_width-1:0] p0_address,
    input  logic [access_width-1:0]  p0_access_num,
    input  logic [data_width-1:0]    p0_data_in,
    output logic                     p0_accept,
    output logic                     p0_write_flag,
    output logic                     p0_read_flag,
    output logic                     p0_done,
    input  logic                     p1_request,
    input  logic                     p1_write,
    input  logic [address_width-1:0] p1_address,
    input  logic [access_width-1:0]  p1_access_num,
    input  logic [data_width-1:0]    p1_data_in,
    output logic                     p1_accept,
    output logic                     p1_write_flag,
    output logic                     p1_read_flag,
    output logic                     p1_done,
    output logic [data_width-1:0]    data_out,
    output logic [address_width-1:0] sd_address,
    output logic [access_width-1:0]  sd_access_num,
    output logic [data_width-1:0]    sd_data_in,
    output logic                     sd_write_request,
    output logic                     sd_read_request,
    input  logic [data_width-1:0]    sd_data_out,
    input  logic                     sd_write_flag,
    input  logic                     sd_read_flag,
    input  logic                     sd_idle
);

    arb_state_e               state_q, state_d;
    logic                     arb_valid, arb_winner, grant, owned;
    logic                     owner_q, owner_d, write_q, write_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [access_width-1:0]  num_q, num_d;

    assign grant = (state_q == ST_IDLE) && sd_idle && arb_valid;
    assign owned = (state_q != ST_IDLE);

    kfsdram_rr_arbiter u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_i     ({p1_request, p0_request}),
        .advance_i (grant),
        .valid_o   (arb_valid),
        .winner_o  (arb_winner)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (grant) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            // A refresh that delays the burst simply keeps us here.
            ST_WAIT_BUSY: if (!sd_idle) state_d = ST_BUSY;
            ST_BUSY:      if (sd_idle) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Command fields are captured once at grant and held for the whole burst.
    always_comb begin
        owner_d = owner_q;
        write_d = write_q;
        addr_d  = addr_q;
        num_d   = num_q;
        if (grant) begin
            owner_d = arb_winner;
            write_d = arb_winner ? p1_write      : p0_write;
            addr_d  = arb_winner ? p1_address    : p0_address;
            num_d   = arb_winner ? p1_access_num : p0_access_num;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            num_q   <= '0;
        end else begin
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
        end
    end

    // Accept is raised in ISSUE, i.e. once the request has actually been latched.
    always_comb begin
        p0_accept        = 1'b0;
        p1_accept        = 1'b0;
        p0_done          = 1'b0;
        p1_done          = 1'b0;
        sd_write_request = 1'b0;
        sd_read_request  = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                p0_accept        = !owner_q;
                p1_accept        = owner_q;
                sd_write_request = write_q;
                sd_read_request  = !write_q;
            end
            ST_DONE: begin
                p0_done = !owner_q;
                p1_done = owner_q;
            end
            default: ;
        endcase
    end

    assign p0_write_flag = owned && !owner_q && sd_write_flag;
    assign p0_read_flag  = owned && !owner_q && sd_read_flag;
    assign p1_write_flag = owned && owner_q && sd_write_flag;
    assign p1_read_flag  = owned && owner_q && sd_read_flag;

    assign sd_data_in    = !owned ? '0 : (owner_q ? p1_data_in : p0_data_in);
    assign data_out      = sd_data_out;
    assign sd_address    = addr_q;
    assign sd_access_num = num_q;

endmodule

// File: tb/tb_kfsdram_arbiter.sv
// Bench for kfsdram_arbiter: a table of burst grants checked through a scoreboard,
// plus hand sequences for busy-controller, dropped-request and mid-burst reset cases.
module tb_kfsdram_arbiter;

    localparam int AW = 25;
    localparam int CW = 10;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          p0_request, p0_write, p1_request, p1_write;
    logic [AW-1:0] p0_address, p1_address;
    logic [CW-1:0] p0_access_num, p1_access_num;
    logic [DW-1:0] p0_data_in, p1_data_in;
    logic          p0_accept, p0_write_flag, p0_read_flag, p0_done;
    logic          p1_accept, p1_write_flag, p1_read_flag, p1_done;
    logic [DW-1:0] data_out, sd_data_in, sd_data_out;
    logic [AW-1:0] sd_address;
    logic [CW-1:0] sd_access_num;
    logic          sd_write_request, sd_read_request;
    logic          sd_write_flag, sd_read_flag, sd_idle;

    always #5 clock = ~clock;

    kfsdram_arbiter #(
        .address_width (AW),
        .access_width  (CW),
        .data_width    (DW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .p0_request       (p0_request),
        .p0_write         (p0_write),
        .p0_address       (p0_address),
        .p0_access_num    (p0_access_num),
        .p0_data_in       (p0_data_in),
        .p0_accept        (p0_accept),
        .p0_write_flag    (p0_write_flag),
        .p0_read_flag     (p0_read_flag),
        .p0_done          (p0_done),
        .p1_request       (p1_request),
        .p1_write         (p1_write),
        .p1_address       (p1_address),
        .p1_access_num    (p1_access_num),
        .p1_data_in       (p1_data_in),
        .p1_accept        (p1_accept),
        .p1_write_flag    (p1_write_flag),
        .p1_read_flag     (p1_read_flag),
        .p1_done          (p1_done),
        .data_out         (data_out),
        .sd_address       (sd_address),
        .sd_access_num    (sd_access_num),
        .sd_data_in       (sd_data_in),
        .sd_write_request (sd_write_request),
        .sd_read_request  (sd_read_request),
        .sd_data_out      (sd_data_out),
        .sd_write_flag    (sd_write_flag),
        .sd_read_flag     (sd_read_flag),
        .sd_idle          (sd_idle)
    );

    typedef struct {
        logic          req0, req1, wr0, wr1;
        logic [AW-1:0] addr0, addr1;
        logic [CW-1:0] num0, num1;
        logic          exp_port, exp_wr;
    } vec_t;

    typedef struct {
        logic          port, wr;
        logic [AW-1:0] addr;
        logic [CW-1:0] num;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full burst from IDLE through DONE with a simple controller model.
    task automatic run_row(input vec_t v);
        exp_t        e;
        logic [3:0]  exp_flags;
        logic [DW-1:0] exp_din;
        sd_idle       = 1'b1;
        p0_request    = v.req0;   p1_request    = v.req1;
        p0_write      = v.wr0;    p1_write      = v.wr1;
        p0_address    = v.addr0;  p1_address    = v.addr1;
        p0_access_num = v.num0;   p1_access_num = v.num1;
        e.port = v.exp_port;
        e.wr   = v.exp_wr;
        e.addr = v.exp_port ? v.addr1 : v.addr0;
        e.num  = v.exp_port ? v.num1  : v.num0;
        sb.push_back(e);
        exp_flags = e.wr ? (e.port ? 4'b1000 : 4'b0010) : (e.port ? 4'b0100 : 4'b0001);
        exp_din   = e.port ? p1_data_in : p0_data_in;

        step();  // ISSUE
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("accept", {p1_accept, p0_accept}, e.port ? 2'b10 : 2'b01);
            check("sd_cmd", {sd_write_request, sd_read_request}, e.wr ? 2'b10 : 2'b01);
            check("sd_address", sd_address, e.addr);
            check("sd_access_num", sd_access_num, e.num);
        end
        if (e.port) p1_request = 1'b0;
        else        p0_request = 1'b0;

        step();  // WAIT_BUSY
        check("cmd_one_pulse", {sd_write_request, sd_read_request, p1_accept, p0_accept}, 4'b0);
        step();  // still WAIT_BUSY: controller slow to start
        check("wait_addr_held", sd_address, e.addr);
        check("wait_no_done", {p1_done, p0_done}, 2'b0);
        sd_idle = 1'b0;

        step();  // BUSY
        if (e.wr) sd_write_flag = 1'b1;
        else      sd_read_flag  = 1'b1;
        sd_data_out = 16'hABCD;
        #1;
        check("flags_w1", {p1_write_flag, p1_read_flag, p0_write_flag, p0_read_flag}, exp_flags);
        check("data_out_w1", data_out, 16'hABCD);
        check("sd_data_in_mux", sd_data_in, exp_din);
        step();
        sd_data_out = 16'hEF01;
        #1;
        check("flags_w2", {p1_write_flag, p1_read_flag, p0_write_flag, p0_read_flag}, exp_flags);
        check("data_out_w2", data_out, 16'hEF01);
        check("busy_num_held", sd_access_num, e.num);
        step();
        sd_write_flag = 1'b0;
        sd_read_flag  = 1'b0;
        sd_idle       = 1'b1;
        #1;
        check("busy_no_done", {p1_done, p0_done}, 2'b0);

        step();  // DONE
        check("done", {p1_done, p0_done}, e.port ? 2'b10 : 2'b01);
        check("done_addr_held", sd_address, e.addr);
        step();  // IDLE
        check("done_one_pulse", {p1_done, p0_done}, 2'b0);
        check("idle_sd_data_in", sd_data_in, 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // req0 req1 wr0 wr1 addr0 addr1 num0 num1 exp_port exp_wr; pointer history carries row to row
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 25'h0000100, 25'h0000200, 10'd4,  10'd8,   1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 25'h0000100, 25'h0000200, 10'd4,  10'd8,   1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 25'h0ABCDE0, 25'h1FFFFFF, 10'd3,  10'h3FF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 25'h0ABCDE0, 25'h1FFFFFF, 10'd3,  10'h3FF, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 25'h1800401, 25'h0000000, 10'd2,  10'd0,   1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 25'h0000000, 25'h0000000, 10'd0,  10'd0,   1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 25'h0000010, 25'h0000020, 10'd1,  10'd5,   1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 25'h0000010, 25'h0000020, 10'd1,  10'd5,   1'b0, 1'b1};

        reset = 1'b1;
        p0_request = 1'b0; p1_request = 1'b0; p0_write = 1'b0; p1_write = 1'b0;
        p0_address = '0; p1_address = '0; p0_access_num = '0; p1_access_num = '0;
        p0_data_in = 16'h1111; p1_data_in = 16'h2222;
        sd_data_out = '0; sd_write_flag = 1'b0; sd_read_flag = 1'b0; sd_idle = 1'b1;
        step();
        step();
        check("rst_pulses", {p1_accept, p0_accept, p1_done, p0_done, sd_write_request, sd_read_request}, 6'b0);
        check("rst_sd_address", sd_address, 25'h0);
        check("rst_sd_access_num", sd_access_num, 10'h0);
        check("rst_sd_data_in", sd_data_in, 16'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_row(vecs[i]);

        // Controller busy, request withdrawn before it could be accepted.
        sd_idle = 1'b0;
        p1_request = 1'b1; p1_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy_no_accept", {p1_accept, p0_accept}, 2'b0);
        end
        p1_request = 1'b0;
        sd_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("dropped_req", {p1_accept, p0_accept, sd_write_request, sd_read_request}, 4'b0);
        end

        // Request held while controller busy is accepted once sd_idle returns.
        sd_idle = 1'b0;
        p0_request = 1'b1; p0_write = 1'b1;
        step();
        step();
        check("init_no_accept", {p1_accept, p0_accept}, 2'b0);
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 25'h0012345, 25'h0, 10'd6, 10'd0, 1'b0, 1'b1};
        run_row(v);

        // Reset in the middle of a burst.
        sd_idle = 1'b1;
        p0_request = 1'b1; p0_write = 1'b0; p0_address = 25'h0155555; p0_access_num = 10'd7;
        step();
        check("abort_accept", {p1_accept, p0_accept}, 2'b01);
        p0_request = 1'b0;
        step();
        sd_idle = 1'b0;
        step();
        sd_read_flag = 1'b1;
        sd_data_out = 16'h5A5A;
        #1;
        check("abort_pre_flag", p0_read_flag, 1'b1);
        check("abort_pre_addr", sd_address, 25'h0155555);
        #2;
        reset = 1'b1;
        #1;
        check("abort_pulses", {p1_accept, p0_accept, p1_done, p0_done, sd_write_request, sd_read_request}, 6'b0);
        check("abort_sd_address", sd_address, 25'h0);
        check("abort_sd_access_num", sd_access_num, 10'h0);
        check("abort_flags", {p1_write_flag, p1_read_flag, p0_write_flag, p0_read_flag}, 4'b0);
        check("abort_sd_data_in", sd_data_in, 16'h0);
        step();
        reset = 1'b0;
        sd_read_flag = 1'b0;
        sd_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", {p1_done, p0_done}, 2'b0);
        end
        // Pointer back at port 0 after reset, so the tie goes to p0.
        v = '{1'b1, 1'b1, 1'b1, 1'b0, 25'h0000ABC, 25'h0000DEF, 10'd2, 10'd3, 1'b0, 1'b1};
        run_row(v);
        v = '{1'b0, 1'b1, 1'b1, 1'b0, 25'h0000ABC, 25'h0000DEF, 10'd2, 10'd3, 1'b1, 1'b0};
        run_row(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kfsdram_arbiter.md
KFSDRAM_ARBITER -- requirements
Module: kfsdram_arbiter

Interface
REQ-001 Parameter: address_width, 25, bank+row+col address width of the KFSDRAM user port.
REQ-002 Parameter: access_width, 10, burst length field width (access_num).
REQ-003 Parameter: data_width, 16, user data width.
REQ-004 clock  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 p0_request / p1_request  in  1  port n access request, level; held until p<n>_accept.
REQ-007 p0_write / p1_write  in  1  1 = write burst, 0 = read burst; sampled with request.
REQ-008 p0_address / p1_address  in  address_width  start address; sampled at accept.
REQ-009 p0_access_num / p1_access_num  in  access_width  burst count; sampled at accept.
REQ-010 p0_data_in / p1_data_in  in  data_width  write data for port n.
REQ-011 p0_accept / p1_accept  out  1  one-cycle pulse: request latched.
REQ-012 p0_write_flag / p1_write_flag, p0_read_flag / p1_read_flag  out  1  controller flags, routed to owner only.
REQ-013 p0_done / p1_done  out  1  one-cycle pulse: owned burst complete.
REQ-014 data_out  out  data_width  controller read data, broadcast to both ports.
REQ-015 sd_address, sd_access_num, sd_data_in, sd_write_request, sd_read_request  out  -  controller command side; sd_data_out, sd_write_flag, sd_read_flag, sd_idle  in  -  controller status side.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, BUSY, DONE.
REQ-017 IDLE: when sd_idle=1 and any request pending, SHALL pick winner by round-robin, latch write/address/access_num, pulse p<n>_accept, go to ISSUE.
REQ-018 Round-robin: priority pointer starts at port 0; after a grant, pointer SHALL move to the other port; single requester always wins.
REQ-019 Simultaneous p0/p1 requests SHALL be granted per pointer; loser stays pending and is granted next.
REQ-020 ISSUE: exactly one of sd_write_request/sd_read_request SHALL pulse for one cycle; next state WAIT_BUSY.
REQ-021 WAIT_BUSY: on sd_idle=0 go to BUSY; controller refresh delaying start SHALL simply extend this state.
REQ-022 BUSY: on sd_idle=1 go to DONE.
REQ-023 DONE: pulse p<owner>_done one cycle, return to IDLE; earliest next accept is the cycle after DONE.
REQ-024 sd_address and sd_access_num SHALL be registered and stable from ISSUE through DONE.
REQ-025 sd_data_in SHALL be combinational mux of owner's p<n>_data_in; zero in IDLE.
REQ-026 sd_write_flag/sd_read_flag SHALL reach only the owner; non-owner flags 0.
REQ-027 Request deasserted before accept SHALL be dropped with no side effect.
REQ-028 access_num=0 SHALL be forwarded unchanged (controller defines semantics).

Reset
REQ-029 On reset: state IDLE, pointer port 0, all accept/done/request pulses 0, sd_address/sd_access_num 0, owner none.
REQ-030 Reset mid-burst SHALL abort immediately; no done pulse issued.

Structure
REQ-031 Package kfsdram_pkg SHALL hold the FSM state enum and default width constants shared with KFSDRAM.
REQ-032 One sub-module kfsdram_rr_arbiter (2-way round-robin pick plus pointer) is natural; rest inline.

Verification
REQ-033 p0 write, address 25'h1800401, access_num 2 -> p0_accept next cycle, one sd_write_request pulse, sd_address held, p0_done after sd_idle returns to 1.
REQ-034 p0 and p1 requests same cycle after reset -> p0 granted first, p1 accepted after p0_done; then simultaneous again -> p0 wins (pointer alternates).
REQ-035 p1 read, model sd_read_flag with sd_data_out 16'hABCD, 16'hEF01 -> p1_read_flag high two cycles, p0_read_flag stays 0, data_out shows both words.
REQ-036 Request while sd_idle=0 (controller init/refresh) -> no accept until sd_idle=1.
REQ-037 Reset asserted in BUSY -> all outputs reset values within same cycle, no p<n>_done, next request accepted normally.
